// File: rtl/sram_bist_sequencer.sv
// Serialises one RTAP debug transaction onto the nibble-wide SRAM BIST bus
// and deserialises the read response returned on bist_rdata.
module sram_bist_sequencer #(
  parameter int unsigned REQ_DATA_WIDTH = 192,
  parameter int unsigned RES_DATA_WIDTH = 256,
  parameter int unsigned NIB            = 4,
  parameter int unsigned BIST_OP_WIDTH  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [7:0]                req_sr_id,
  input  logic [7:0]                req_bsel,
  input  logic [15:0]               req_addr,
  input  logic [REQ_DATA_WIDTH-1:0] req_wdata,
  output logic                      resp_valid,
  output logic [RES_DATA_WIDTH-1:0] resp_rdata,
  output logic [BIST_OP_WIDTH-1:0]  bist_command,
  output logic [NIB-1:0]            bist_data,
  input  logic [NIB-1:0]            bist_rdata
);

  localparam int unsigned HDR_W   = 32;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned WR_NIBS = REQ_DATA_WIDTH / NIB;
  localparam int unsigned RD_NIBS = RES_DATA_WIDTH / NIB;

  localparam logic [CNT_W-1:0] ID_LAST   = CNT_W'(8 / NIB - 1);
  localparam logic [CNT_W-1:0] BSEL_LAST = CNT_W'(8 / NIB - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(16 / NIB - 1);
  localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_NIBS - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_NIBS - 1);

  localparam logic [BIST_OP_WIDTH-1:0] OP_NOP           = BIST_OP_WIDTH'(0);
  localparam logic [BIST_OP_WIDTH-1:0] OP_SHIFT_ID      = BIST_OP_WIDTH'(1);
  localparam logic [BIST_OP_WIDTH-1:0] OP_SHIFT_BSEL    = BIST_OP_WIDTH'(2);
  localparam logic [BIST_OP_WIDTH-1:0] OP_SHIFT_ADDRESS = BIST_OP_WIDTH'(3);
  localparam logic [BIST_OP_WIDTH-1:0] OP_SHIFT_DATA    = BIST_OP_WIDTH'(4);
  localparam logic [BIST_OP_WIDTH-1:0] OP_READ          = BIST_OP_WIDTH'(5);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ID,
    S_BSEL,
    S_ADDR,
    S_WDATA,
    S_WGAP,
    S_RCMD,
    S_RGAP,
    S_RDATA,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  state_t                    field_next;
  logic                      field_last;
  logic                      hdr_shift;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [HDR_W-1:0]          hdr_q, hdr_d;
  logic [REQ_DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [RES_DATA_WIDTH-1:0] rsh_q, rsh_d;
  logic                      wr_q, wr_d;
  logic                      ready_d;
  logic                      resp_valid_d;
  logic [RES_DATA_WIDTH-1:0] resp_rdata_d;
  logic [BIST_OP_WIDTH-1:0]  cmd_d;
  logic [NIB-1:0]            data_d;

  // Next state, shadow shift registers and the bus word for the coming cycle
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hdr_d        = hdr_q;
    wdat_d       = wdat_q;
    rsh_d        = rsh_q;
    wr_d         = wr_q;
    ready_d      = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata;
    cmd_d        = OP_NOP;
    data_d       = '0;
    field_last   = 1'b0;
    field_next   = S_IDLE;
    hdr_shift    = 1'b0;

    case (state_q)
      S_IDLE:  field_last = 1'b0;
      S_ID:    begin field_last = (cnt_q == ID_LAST);   field_next = S_BSEL; end
      S_BSEL:  begin field_last = (cnt_q == BSEL_LAST); field_next = S_ADDR; end
      S_ADDR:  begin
        field_last = (cnt_q == ADDR_LAST);
        field_next = wr_q ? S_WDATA : S_RCMD;
      end
      S_WDATA: begin field_last = (cnt_q == WR_LAST); field_next = S_WGAP; end
      S_WGAP:  begin field_last = 1'b1; field_next = S_DONE; end
      S_RCMD:  begin field_last = 1'b1; field_next = S_RGAP; end
      S_RGAP:  begin field_last = 1'b1; field_next = S_RDATA; end
      S_RDATA: begin
        field_last = (cnt_q == RD_LAST);
        field_next = S_DONE;
        rsh_d      = {rsh_q[RES_DATA_WIDTH-NIB-1:0], bist_rdata};
      end
      S_DONE:  begin field_last = 1'b1; field_next = S_IDLE; end
      default: begin field_last = 1'b1; field_next = S_IDLE; end
    endcase

    if (state_q == S_IDLE) begin
      if (req_valid) begin
        state_d = S_ID;
        cnt_d   = '0;
        hdr_d   = {req_sr_id, req_bsel, req_addr};
        wdat_d  = req_wdata;
        wr_d    = req_wr;
      end
    end else if (field_last) begin
      state_d = field_next;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Bus word is a function of the state being entered, so it lines up with that state
    case (state_d)
      S_IDLE:  ready_d = 1'b1;
      S_ID:    begin cmd_d = OP_SHIFT_ID;      hdr_shift = 1'b1; end
      S_BSEL:  begin cmd_d = OP_SHIFT_BSEL;    hdr_shift = 1'b1; end
      S_ADDR:  begin cmd_d = OP_SHIFT_ADDRESS; hdr_shift = 1'b1; end
      S_WDATA: begin
        cmd_d  = OP_SHIFT_DATA;
        data_d = wdat_d[REQ_DATA_WIDTH-1 -: NIB];
        wdat_d = wdat_d << NIB;
      end
      S_RCMD:  cmd_d = OP_READ;
      S_RDATA: cmd_d = OP_SHIFT_DATA;
      S_DONE:  begin
        resp_valid_d = 1'b1;
        if (!wr_q) resp_rdata_d = rsh_d;
      end
      default: cmd_d = OP_NOP;
    endcase

    // ID, BSEL and ADDR form one contiguous MS-first header stream
    if (hdr_shift) begin
      data_d = hdr_d[HDR_W-1 -: NIB];
      hdr_d  = hdr_d << NIB;
    end
  end

  // State, shadow and registered bus/response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      hdr_q        <= '0;
      wdat_q       <= '0;
      rsh_q        <= '0;
      wr_q         <= 1'b0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      bist_command <= OP_NOP;
      bist_data    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hdr_q        <= hdr_d;
      wdat_q       <= wdat_d;
      rsh_q        <= rsh_d;
      wr_q         <= wr_d;
      req_ready    <= ready_d;
      resp_valid   <= resp_valid_d;
      resp_rdata   <= resp_rdata_d;
      bist_command <= cmd_d;
      bist_data    <= data_d;
    end
  end

endmodule

// File: tb/tb_sram_bist_sequencer.sv
// Bench for sram_bist_sequencer: a 32-bit sp_ram slave on the bus, a
// spec-level expected bus stream per transaction and a memory reference model.
module tb_sram_bist_sequencer;

  localparam int unsigned REQ_W = 192;
  localparam int unsigned RES_W = 256;
  localparam int unsigned NIB   = 4;
  localparam int unsigned OPW   = 3;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ID   = 3'd1;
  localparam logic [2:0] OP_BSEL = 3'd2;
  localparam logic [2:0] OP_ADDR = 3'd3;
  localparam logic [2:0] OP_DATA = 3'd4;
  localparam logic [2:0] OP_READ = 3'd5;

  localparam logic [7:0] SLAVE_ID = 8'h2A;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [7:0]       req_sr_id;
  logic [7:0]       req_bsel;
  logic [15:0]      req_addr;
  logic [REQ_W-1:0] req_wdata;
  logic             resp_valid;
  logic [RES_W-1:0] resp_rdata;
  logic [OPW-1:0]   bist_command;
  logic [NIB-1:0]   bist_data;
  logic [NIB-1:0]   bist_rdata;

  int total = 0;
  int bad   = 0;
  bit b2b_pending = 1'b0;

  sram_bist_sequencer #(
    .REQ_DATA_WIDTH(REQ_W),
    .RES_DATA_WIDTH(RES_W),
    .NIB           (NIB),
    .BIST_OP_WIDTH (OPW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_sr_id   (req_sr_id),
    .req_bsel    (req_bsel),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .bist_command(bist_command),
    .bist_data   (bist_data),
    .bist_rdata  (bist_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sp_ram slave: 256 x 32-bit words, low address byte selects the word
  logic [31:0]      smem [256] = '{19: 32'hDEADBEEF, default: 32'h0};
  logic [7:0]       s_id;
  logic [7:0]       s_addr;
  logic [31:0]      s_wd;
  logic [RES_W-1:0] s_res;
  logic             s_rd_pend, s_rd_mode, s_wr_pend;

  assign bist_rdata = (s_rd_mode && bist_command == OP_DATA) ? s_res[RES_W-1 -: NIB] : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rd_pend <= 1'b0;
      s_rd_mode <= 1'b0;
      s_wr_pend <= 1'b0;
    end else begin
      case (bist_command)
        OP_ID:   s_id   <= {s_id[3:0], bist_data};
        OP_ADDR: s_addr <= {s_addr[3:0], bist_data};
        OP_DATA: begin
          if (s_rd_mode) s_res <= s_res << NIB;
          else begin
            s_wd      <= {s_wd[27:0], bist_data};
            s_wr_pend <= 1'b1;
          end
        end
        OP_READ: s_rd_pend <= 1'b1;
        OP_BSEL: s_rd_mode <= 1'b0;
        default: begin
          if (s_wr_pend) begin
            if (s_id == SLAVE_ID) smem[s_addr] <= s_wd;
            s_wr_pend <= 1'b0;
          end
          if (s_rd_pend) begin
            s_res     <= (s_id == SLAVE_ID) ? RES_W'(smem[s_addr]) : '0;
            s_rd_pend <= 1'b0;
            s_rd_mode <= 1'b1;
          end else begin
            s_rd_mode <= 1'b0;
          end
        end
      endcase
    end
  end

  // Reference model of memory contents and held response
  logic [31:0]      ref_mem [256] = '{19: 32'hDEADBEEF, default: 32'h0};
  logic [RES_W-1:0] cur_rd = '0;

  function automatic logic [RES_W-1:0] ref_step(input logic wr, input logic [7:0] id,
                                                input logic [7:0] a8, input logic [31:0] wd32);
    if (wr) begin
      if (id == SLAVE_ID) ref_mem[a8] = wd32;
    end else begin
      cur_rd = (id == SLAVE_ID) ? RES_W'(ref_mem[a8]) : '0;
    end
    return cur_rd;
  endfunction

  function automatic logic [REQ_W-1:0] rand_wd();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Expected bus stream after accept, one entry per cycle
  logic [2:0] exp_cmd [80];
  logic [3:0] exp_dat [80];
  int         exp_len;

  task automatic build_exp(input logic wr, input logic [7:0] id, input logic [7:0] bsel,
                           input logic [15:0] addr, input logic [REQ_W-1:0] wd);
    logic [31:0]      hdr;
    logic [REQ_W-1:0] w;
    int n;
    hdr = {id, bsel, addr};
    n   = 0;
    for (int i = 0; i < 8; i++) begin
      exp_cmd[n] = (i < 2) ? OP_ID : (i < 4) ? OP_BSEL : OP_ADDR;
      exp_dat[n] = hdr[31:28];
      hdr = hdr << 4;
      n++;
    end
    if (wr) begin
      w = wd;
      for (int i = 0; i < 48; i++) begin
        exp_cmd[n] = OP_DATA;
        exp_dat[n] = w[REQ_W-1 -: 4];
        w = w << 4;
        n++;
      end
      exp_cmd[n] = OP_NOP; exp_dat[n] = 4'h0; n++;
    end else begin
      exp_cmd[n] = OP_READ; exp_dat[n] = 4'h0; n++;
      exp_cmd[n] = OP_NOP;  exp_dat[n] = 4'h0; n++;
      for (int i = 0; i < 64; i++) begin
        exp_cmd[n] = OP_DATA; exp_dat[n] = 4'h0; n++;
      end
    end
    exp_cmd[n] = OP_NOP; exp_dat[n] = 4'h0; n++;
    exp_len = n;
  endtask

  task automatic chk(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issue one transaction, check its bus stream, latency and response
  task automatic run_txn(input string tag, input logic wr, input logic [7:0] id,
                         input logic [7:0] bsel, input logic [15:0] addr,
                         input logic [REQ_W-1:0] wd, input logic [RES_W-1:0] exp_rd,
                         input int exp_lat, input bit toggle, input bit hold, input int abort_at);
    int   waitc, lat, bad_k;
    bit   ok, aborted, quiet;
    logic [2:0] g_cmd;
    logic [3:0] g_dat;
    logic g_rv, g_rdy;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_sr_id = id; req_bsel = bsel;
    req_addr = addr; req_wdata = wd;
    if (b2b_pending) chk({tag, "_b2b_ready"}, RES_W'(req_ready), RES_W'(1'b1));
    waitc = 0;
    while (req_ready !== 1'b1 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (req_ready !== 1'b1) begin
      chk({tag, "_accept"}, RES_W'(req_ready), RES_W'(1'b1));
      req_valid = 1'b0;
      b2b_pending = 1'b0;
      return;
    end
    build_exp(wr, id, bsel, addr, wd);
    ok = 1'b1; aborted = 1'b0; lat = -1; bad_k = -1;
    g_cmd = '0; g_dat = '0; g_rv = 1'b0; g_rdy = 1'b0;
    for (int k = 1; k <= exp_len; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1 && lat < 0) lat = k + 1;
      if (ok && (bist_command !== exp_cmd[k-1] || bist_data !== exp_dat[k-1] ||
                 resp_valid !== (k == exp_len) || req_ready !== 1'b0)) begin
        ok = 1'b0; bad_k = k;
        g_cmd = bist_command; g_dat = bist_data; g_rv = resp_valid; g_rdy = req_ready;
      end
      if (k == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (toggle) begin
        req_valid = 1'($urandom); req_wr = 1'($urandom); req_sr_id = 8'($urandom);
        req_bsel = 8'($urandom); req_addr = 16'($urandom); req_wdata = rand_wd();
      end else begin
        req_valid = hold;
      end
      if (k == exp_len) req_valid = hold;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_stream: beat %0d got cmd=%0d data=%h valid=%b ready=%b want cmd=%0d data=%h valid=%b ready=0",
               tag, bad_k, g_cmd, g_dat, g_rv, g_rdy, exp_cmd[bad_k-1], exp_dat[bad_k-1],
               bad_k == exp_len);
    end
    if (aborted) begin
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_rst_cmd"},   RES_W'(bist_command), RES_W'(OP_NOP));
      chk({tag, "_rst_data"},  RES_W'(bist_data),    RES_W'(4'h0));
      chk({tag, "_rst_ready"}, RES_W'(req_ready),    RES_W'(1'b1));
      chk({tag, "_rst_valid"}, RES_W'(resp_valid),   RES_W'(1'b0));
      chk({tag, "_rst_rdata"}, resp_rdata,           '0);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (resp_valid !== 1'b0 || bist_command !== OP_NOP) quiet = 1'b0;
      end
      chk({tag, "_post_abort_quiet"}, RES_W'(quiet), RES_W'(1'b1));
      cur_rd = '0;
      b2b_pending = 1'b0;
      return;
    end
    chk({tag, "_latency"}, RES_W'(lat), RES_W'(exp_lat));
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    b2b_pending = hold;
  endtask

  typedef struct {
    logic             wr;
    logic [7:0]       id;
    logic [7:0]       bsel;
    logic [15:0]      addr;
    logic [REQ_W-1:0] wd;
    logic [RES_W-1:0] exp_rd;
    int               exp_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [REQ_W-1:0] wd;
    logic [RES_W-1:0] e;
    logic             wr;
    logic [7:0]       id;
    logic [15:0]      addr;
    bit               idle_ok, tg, hd;

    vecs[0] = '{1'b1, 8'h2A, 8'h00, 16'h0013,
                192'hCAFEF00D_0123456789ABCDEF_0011223344556677_DEADBEEF, '0, 59};
    vecs[1] = '{1'b0, 8'h2A, 8'h00, 16'h0013, '0, 256'hDEADBEEF, 76};
    vecs[2] = '{1'b0, 8'h11, 8'h00, 16'h0013, '0, '0, 76};
    vecs[3] = '{1'b1, 8'h2A, 8'h5C, 16'hFFFF, '1, '0, 59};
    vecs[4] = '{1'b0, 8'h2A, 8'h00, 16'hFFFF, '0, 256'hFFFFFFFF, 76};
    vecs[5] = '{1'b1, 8'h55, 8'h00, 16'h0013, 192'h12345678, 256'hFFFFFFFF, 59};
    vecs[6] = '{1'b0, 8'h2A, 8'h00, 16'h0013, '0, 256'hDEADBEEF, 76};
    vecs[7] = '{1'b0, 8'h2A, 8'h00, 16'h0000, '0, '0, 76};

    rst_n = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_sr_id = '0;
    req_bsel = '0; req_addr = '0; req_wdata = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_cmd",   RES_W'(bist_command), RES_W'(OP_NOP));
    chk("reset_data",  RES_W'(bist_data),    RES_W'(4'h0));
    chk("reset_ready", RES_W'(req_ready),    RES_W'(1'b1));
    chk("reset_valid", RES_W'(resp_valid),   RES_W'(1'b0));
    chk("reset_rdata", resp_rdata,           '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    idle_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready !== 1'b1 || bist_command !== OP_NOP || bist_data !== 4'h0 ||
          resp_valid !== 1'b0) idle_ok = 1'b0;
    end
    chk("idle_100", RES_W'(idle_ok), RES_W'(1'b1));

    // Directed table
    for (int i = 0; i < 8; i++) begin
      e = ref_step(vecs[i].wr, vecs[i].id, vecs[i].addr[7:0], vecs[i].wd[31:0]);
      run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].id, vecs[i].bsel, vecs[i].addr,
              vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_lat, 1'b0, 1'b0, -1);
    end

    // Back-to-back write then read with req_valid held high
    wd = rand_wd();
    e = ref_step(1'b1, SLAVE_ID, 8'h42, wd[31:0]);
    run_txn("b2b_wr", 1'b1, SLAVE_ID, 8'h03, 16'h0042, wd, e, 59, 1'b0, 1'b1, -1);
    e = ref_step(1'b0, SLAVE_ID, 8'h42, 32'h0);
    run_txn("b2b_rd", 1'b0, SLAVE_ID, 8'h03, 16'h0042, '0, e, 76, 1'b0, 1'b0, -1);

    // req_valid toggled with junk fields while busy
    wd = rand_wd();
    e = ref_step(1'b1, SLAVE_ID, 8'h05, wd[31:0]);
    run_txn("busy_wr", 1'b1, SLAVE_ID, 8'hA5, 16'h0005, wd, e, 59, 1'b1, 1'b0, -1);
    e = ref_step(1'b0, SLAVE_ID, 8'h05, 32'h0);
    run_txn("busy_rd", 1'b0, SLAVE_ID, 8'h00, 16'h0005, '0, e, 76, 1'b1, 1'b0, -1);

    // Reset during RDATA nibble 30, then a clean read
    run_txn("abort", 1'b0, SLAVE_ID, 8'h00, 16'h0013, '0, '0, 76, 1'b0, 1'b0, 41);
    e = ref_step(1'b0, SLAVE_ID, 8'h13, 32'h0);
    run_txn("after_abort", 1'b0, SLAVE_ID, 8'h00, 16'h0013, '0, e, 76, 1'b0, 1'b0, -1);

    // Randomized transactions against the reference model
    for (int i = 0; i < 24; i++) begin
      wr   = 1'($urandom);
      id   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : SLAVE_ID;
      addr = 16'($urandom_range(0, 7));
      wd   = rand_wd();
      tg   = ($urandom_range(0, 2) == 0);
      hd   = (i != 23) && ($urandom_range(0, 2) == 0);
      e    = ref_step(wr, id, addr[7:0], wd[31:0]);
      run_txn($sformatf("rnd%0d", i), wr, id, 8'($urandom), addr, wd, e,
              wr ? 59 : 76, tg, hd, -1);
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
